// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer:
// capture FSM states and the default word/counter sizing.
package sipo_pkg;

    // Capture FSM: waiting for a frame start, or shifting bits in
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Default deserialized word width
    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width needed to index a word of the given width
    function automatic int sel_for(input int width);
        return $clog2(width);
    endfunction

    // Default bit-counter width, derived from the default word width
    localparam int DEFAULT_SEL = sel_for(DEFAULT_WIDTH);

endpackage

// File: rtl/sipo_deser_bit_counter.sv
// Bit-position counter for the deserializer. Counts the serial bits of
// a frame and flags the last bit position (WIDTH-1).
module bit_counter
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEL   = DEFAULT_SEL
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clear,
    input  logic           enable,
    output logic [SEL-1:0] count,
    output logic           tc
);

    localparam logic [SEL-1:0] LAST = SEL'(WIDTH - 1);

    // Counter register. Clear together with enable means "restart and
    // count the bit taken this cycle", so the counter lands on 1; that is
    // how a frame start (which consumes bit 0 immediately) is expressed.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear && enable) begin
            count <= SEL'(1);
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + SEL'(1);
        end
    end

    // Terminal count: the bit sampled this cycle is the last of the word
    always_comb begin
        tc = (count == LAST);
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer. Assembles LSB-first serial frames
// into WIDTH-bit words, presents them on a valid/ready output register,
// and raises a sticky overrun flag when a finished word has to be dropped
// because the previous one is still waiting to be accepted.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEL   = DEFAULT_SEL
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             start,
    input  logic             out_ready,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    state_t state_q;
    state_t state_d;

    logic [SEL-1:0]   count;
    logic             at_last;
    logic             cnt_clear;
    logic             cnt_enable;

    logic             in_shift;
    logic             complete;
    logic             accept;
    logic             load_word;
    logic             drop_word;

    // Bits 0..WIDTH-2 of the frame; the final bit goes straight into the
    // output word from ser_in, so it never needs a shift-register slot.
    logic [WIDTH-2:0] shift_q;
    logic [WIDTH-2:0] shift_d;

    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic             overrun_q;
    logic             overrun_d;

    bit_counter #(
        .WIDTH (WIDTH),
        .SEL   (SEL)
    ) u_bit_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (count),
        .tc     (at_last)
    );

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a start always (re)enters SHIFT, the last bit leaves it
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (start) begin
                    state_d = SHIFT;
                end else if (at_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame control: a start overrides a coinciding completion, and the
    // output handshake decides whether a finished word loads or is dropped
    always_comb begin
        in_shift   = (state_q == SHIFT);
        complete   = in_shift && at_last && !start;
        cnt_clear  = start || (in_shift && at_last);
        cnt_enable = start || (in_shift && !at_last);
        accept     = out_valid_q && out_ready;
        load_word  = complete && (!out_valid_q || out_ready);
        drop_word  = complete && out_valid_q && !out_ready;
    end

    // Shift-register next value: a start wipes the partial word and takes
    // bit 0; otherwise each mid-frame cycle fills the slot at count
    always_comb begin
        shift_d = shift_q;
        if (start) begin
            shift_d    = '0;
            shift_d[0] = ser_in;
        end else if (in_shift && !at_last) begin
            for (int i = 0; i < WIDTH - 1; i++) begin
                if (count == SEL'(i)) begin
                    shift_d[i] = ser_in;
                end
            end
        end
    end

    // Shift register
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    // Output register next values: load on completion when the slot is
    // free or being emptied this cycle, otherwise drop and flag overrun;
    // a new overrun beats a simultaneous clear request
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (load_word) begin
            out_data_d  = {ser_in, shift_q};
            out_valid_d = 1'b1;
        end else if (accept) begin
            out_valid_d = 1'b0;
        end

        overrun_d = overrun_q;
        if (drop_word) begin
            overrun_d = 1'b1;
        end else if (ovf_clr) begin
            overrun_d = 1'b0;
        end
    end

    // Output and status registers
    always_ff @(posedge clock) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // Port drive; busy is simply "a frame is being captured"
    always_comb begin
        out_data  = out_data_q;
        out_valid = out_valid_q;
        overrun   = overrun_q;
        busy      = in_shift;
    end

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: directed frame scenarios followed
// by randomized traffic, all compared against a frame-level reference
// model that collects serial bits in a queue.
module tb_sipo_deser;

    localparam int WIDTH = 8;
    localparam int SEL   = 3;

    logic             clock;
    logic             reset;
    logic             ser_in;
    logic             start;
    logic             out_ready;
    logic             ovf_clr;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             busy;
    logic             overrun;

    int totalChecks = 0;
    int badChecks   = 0;

    // Reference model state
    bit               frameBits[$];
    bit               mInFrame = 1'b0;
    logic [WIDTH-1:0] mData    = '0;
    logic             mValid   = 1'b0;
    logic             mOverrun = 1'b0;

    sipo_deser #(
        .WIDTH (WIDTH),
        .SEL   (SEL)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ser_in    (ser_in),
        .start     (start),
        .out_ready (out_ready),
        .ovf_clr   (ovf_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    // Free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Frame-level model: frames are lists of bits; a word exists once
    // WIDTH bits have arrived after a start with no intervening start
    task automatic modelStep(input logic st, input logic si, input logic rdy,
                             input logic clr, input logic rst);
        logic [WIDTH-1:0] word;
        bit               done;
        bit               wasValid;
        if (rst) begin
            frameBits.delete();
            mInFrame = 1'b0;
            mData    = '0;
            mValid   = 1'b0;
            mOverrun = 1'b0;
            return;
        end
        done     = 1'b0;
        wasValid = mValid;
        word     = '0;
        if (st) begin
            frameBits.delete();
            frameBits.push_back(si);
            mInFrame = 1'b1;
        end else if (mInFrame) begin
            frameBits.push_back(si);
            if (frameBits.size() == WIDTH) begin
                for (int i = 0; i < WIDTH; i++) begin
                    word[i] = frameBits[i];
                end
                done     = 1'b1;
                mInFrame = 1'b0;
                frameBits.delete();
            end
        end
        if (done && (!wasValid || rdy)) begin
            mData  = word;
            mValid = 1'b1;
        end else if (wasValid && rdy) begin
            mValid = 1'b0;
        end
        if (done && wasValid && !rdy) begin
            mOverrun = 1'b1;
        end else if (clr) begin
            mOverrun = 1'b0;
        end
    endtask

    // One clock cycle: drive inputs, advance the model at the edge and
    // compare all outputs shortly after it
    task automatic applyStimulus(input logic st, input logic si, input logic rdy,
                                 input logic clr, input logic rst);
        start     = st;
        ser_in    = si;
        out_ready = rdy;
        ovf_clr   = clr;
        reset     = rst;
        @(posedge clock);
        modelStep(st, si, rdy, clr, rst);
        #1;
        checkOutput("out_data", 32'(out_data), 32'(mData));
        checkOutput("out_valid", 32'(out_valid), 32'(mValid));
        checkOutput("busy", 32'(busy), 32'(mInFrame));
        checkOutput("overrun", 32'(overrun), 32'(mOverrun));
    endtask

    // Send a whole frame LSB first; lastRdy is out_ready in the final bit cycle
    task automatic sendFrame(input logic [WIDTH-1:0] word, input logic rdy,
                             input logic lastRdy, input logic clr);
        for (int i = 0; i < WIDTH; i++) begin
            applyStimulus(i == 0, word[i], (i == WIDTH - 1) ? lastRdy : rdy, clr, 1'b0);
        end
    endtask

    initial begin
        start     = 1'b0;
        ser_in    = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        reset     = 1'b1;

        // Reset state
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data", 32'(out_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_ignores_ser", 32'(busy), 32'd0);

        // Single frame 0xA5, consumed immediately
        sendFrame(8'hA5, 1'b1, 1'b1, 1'b0);
        checkOutput("a5_data", 32'(out_data), 32'hA5);
        checkOutput("a5_valid", 32'(out_valid), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("a5_one_cycle", 32'(out_valid), 32'd0);

        // Back-to-back 0x3C / 0xC3 with no ready: second word dropped
        sendFrame(8'h3C, 1'b0, 1'b0, 1'b0);
        sendFrame(8'hC3, 1'b0, 1'b0, 1'b0);
        checkOutput("ovr_hold_data", 32'(out_data), 32'h3C);
        checkOutput("ovr_flag", 32'(overrun), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("ovr_cleared", 32'(overrun), 32'd0);
        checkOutput("ovr_still_valid", 32'(out_valid), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("ovr_drained", 32'(out_valid), 32'd0);

        // Same, but ready in the second completion cycle: word replaced
        sendFrame(8'h3C, 1'b0, 1'b0, 1'b0);
        sendFrame(8'hC3, 1'b0, 1'b1, 1'b0);
        checkOutput("swap_data", 32'(out_data), 32'hC3);
        checkOutput("swap_valid", 32'(out_valid), 32'd1);
        checkOutput("swap_no_ovr", 32'(overrun), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Restart after 4 bits, then a full 0xFF frame
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            checkOutput("restart_no_early_valid", 32'(out_valid), 32'd0);
            applyStimulus(i == 0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("restart_data", 32'(out_data), 32'hFF);
        checkOutput("restart_valid", 32'(out_valid), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Start coinciding with the last bit of a frame discards it
        sendFrame(8'h7E, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH - 1; i++) applyStimulus(i == 0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("coincide_no_valid", 32'(out_valid), 32'd0);
        checkOutput("coincide_busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Reset at bit 5 of a frame, then ser_in without start is ignored
        sendFrame(8'h5A, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("midrst_data", 32'(out_data), 32'd0);
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < WIDTH + 2; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("midrst_needs_start", 32'(out_valid), 32'd0);
        sendFrame(8'h96, 1'b0, 1'b0, 1'b0);
        checkOutput("midrst_new_frame", 32'(out_data), 32'h96);

        // Overrun while ovf_clr is held high: set wins
        sendFrame(8'h11, 1'b0, 1'b0, 1'b1);
        checkOutput("setwins_flag", 32'(overrun), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("setwins_cleared", 32'(overrun), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            applyStimulus($urandom_range(0, 11) == 0,
                          1'($urandom),
                          $urandom_range(0, 2) != 0,
                          $urandom_range(0, 15) == 0,
                          $urandom_range(0, 299) == 0);
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 8: deserialized word width in bits, minimum 2.
REQ-002 Parameter SEL, default 3: bit-counter width; it SHALL equal ceil(log2(WIDTH)).
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ser_in  input  1  serial data from the upstream parallel-to-serial stage, LSB first.
REQ-006 start  input  1  frame-start strobe, high in the cycle that bit 0 is on ser_in.
REQ-007 out_ready  input  1  downstream ready to accept out_data.
REQ-008 ovf_clr  input  1  clears the overrun flag.
REQ-009 out_data  output  WIDTH  assembled word; bit i = i-th serial bit received.
REQ-010 out_valid  output  1  out_data holds an unaccepted word.
REQ-011 busy  output  1  frame capture in progress.
REQ-012 overrun  output  1  sticky flag: a completed word was dropped.

Function
REQ-013 FSM states: IDLE and SHIFT; busy SHALL be high exactly in SHIFT.
REQ-014 IDLE, start=1 -> sample ser_in into shift bit 0, set count=1, go to SHIFT; start=0 -> stay IDLE, ser_in ignored.
REQ-015 SHIFT: each cycle sample ser_in into shift bit [count], count+1.
REQ-016 SHIFT, sample with count=WIDTH-1 -> word complete, return to IDLE.
REQ-017 start=1 in SHIFT: discard partial word, restart at bit 0 per REQ-014; no overrun and no out_valid.
REQ-018 Start and completion coincide (count=WIDTH-1, start=1): start wins per REQ-017; the partial word is discarded.
REQ-019 Latency: start in cycle T -> out_valid high from cycle T+WIDTH; out_data valid in the same cycle.
REQ-020 Handshake: a word is accepted in a cycle with out_valid=1 and out_ready=1; out_valid drops the next cycle unless REQ-022 applies.
REQ-021 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-022 Completion in a cycle with out_valid=1 and out_ready=1: the new word loads and out_valid stays 1; no overrun.
REQ-023 Completion in a cycle with out_valid=1 and out_ready=0: the new word is dropped, the held word is kept, and overrun is set next cycle.
REQ-024 Overrun SHALL be cleared only by reset or ovf_clr=1.
REQ-025 ovf_clr and a new overrun event in the same cycle -> overrun=1 (set wins).
REQ-026 Back-to-back frames: start in the cycle after the last bit of the previous frame SHALL be accepted without a gap.
REQ-027 out_ready is ignored while out_valid=0.

Reset
REQ-028 Reset -> state=IDLE, count=0, shift register=0, out_data=0, out_valid=0, busy=0, overrun=0.
REQ-029 Reset mid-frame: the partial word is discarded; the first ser_in sample after reset release needs a fresh start.
REQ-030 Reset has priority over start, out_ready and ovf_clr in the same cycle.

Structure
REQ-031 Shared package sipo_pkg: FSM state enum (IDLE, SHIFT) and default WIDTH/SEL constants.
REQ-032 One sub-module, bit_counter (SEL bits, synchronous clear/enable, terminal-count output at WIDTH-1); everything else inline in sipo_deser.

Verification
REQ-033 start at T, ser_in bits 1,0,1,0,0,1,0,1 (LSB first), out_ready=1 -> out_data=8'hA5, out_valid=1 at T+8 for one cycle.
REQ-034 Two back-to-back frames 8'h3C then 8'hC3, out_ready=0 -> out_data holds 8'h3C; overrun=1 after second completion; ovf_clr -> 0.
REQ-035 Same as REQ-034 but out_ready=1 in the second completion cycle -> out_data=8'hC3, out_valid stays 1, overrun=0.
REQ-036 start, 4 bits, start again with 8'hFF -> out_data=8'hFF at 8 cycles after the second start; no earlier out_valid.
REQ-037 Reset asserted at bit 5 of a frame -> all outputs 0 next cycle; no out_valid until a new start plus 8 cycles.
REQ-038 ovf_clr held high while an overrun occurs -> overrun=1 next cycle.
